spell_dbg_port: RTL and testbench
=================================

Name: spell_dbg_port

Overview:
- Serial debug front-end sitting directly upstream of the SPELL CPU core.
- Converts the pin-level i_load / i_dump / i_shift_in / i_reg_sel protocol into parallel register write and read transactions on the core's PC, SP, EXEC and stack-top registers.
- Serialises read data back out on o_shift_out.
- Pins are asynchronous to clk; the block synchronises them and detects strobe edges.

Parameters:
- DATA_W, 8: register width shifted per transaction.
- SYNC_STAGES, 2: synchroniser flops per input pin (minimum 2).

Ports:
- clk  in  1  system clock.
- reset  in  1  reset; synchronous, active-high.
- i_load  in  1  async pin; each rising edge shifts one write bit in.
- i_dump  in  1  async pin; each rising edge starts or advances a read dump.
- i_shift_in  in  1  async serial write data, MSB first.
- i_reg_sel  in  2  async register select: 0=PC, 1=SP, 2=EXEC, 3=STACK.
- o_shift_out  out  1  serial read data, MSB first.
- o_wr_valid  out  1  write request to core; held until accepted.
- i_wr_ready  in  1  core accepts the write this cycle.
- o_wr_sel  out  2  write target register.
- o_wr_data  out  DATA_W  write value.
- o_rd_req  out  1  one-cycle read request.
- o_rd_sel  out  2  read target register.
- i_rd_data  in  DATA_W  core read data, valid exactly 1 cycle after o_rd_req.
- o_busy  out  1  high whenever state != IDLE.

Behaviour:
Synchronisation and strobes
- i_load, i_dump, i_shift_in and i_reg_sel each pass through SYNC_STAGES flops.
- A load or dump strobe is a 0->1 transition of the synchronised signal.
- Latency from pin edge to strobe: SYNC_STAGES+1 cycles.

Reset
- All sync flops, shift register, bit counter and outputs are 0; state is IDLE.
- Reset mid-transaction drops o_wr_valid immediately, without a handshake.

States: IDLE, LOAD, WR_PEND, RD_REQ, RD_CAP, DUMP.

Load path
- On a load strobe in IDLE, LOAD or DUMP: shreg <= {shreg[DATA_W-2:0], shift_in_s}; cnt++; state = LOAD.
- A load strobe in DUMP first aborts the dump (cnt cleared); that strobe is bit 1 of the new load.
- On the DATA_W-th strobe: latch reg_sel into o_wr_sel and go to WR_PEND.
- In WR_PEND, starting the next cycle: o_wr_valid=1 and o_wr_data=shreg, both stable.
- At the first posedge with i_wr_ready=1: o_wr_valid=0, cnt=0, state = IDLE.
- All strobes in WR_PEND are ignored.

Dump path
- A dump strobe in IDLE or LOAD starts a dump.
  - A partial load (cnt 1..DATA_W-1) is discarded, with no write.
  - cnt=1, o_rd_sel=reg_sel_s, state = RD_REQ.
- RD_REQ: o_rd_req=1 for exactly one cycle, then RD_CAP.
- RD_CAP: shreg <= i_rd_data, then DUMP.
- Strobes in RD_REQ and RD_CAP are ignored.
- DUMP, on each dump strobe: shreg <= {shreg[DATA_W-2:0],1'b0}; cnt++.
  - When cnt reaches DATA_W: state = IDLE, cnt=0.
  - shreg is not cleared, so o_shift_out keeps showing bit 0.

Outputs and arbitration
- o_shift_out = shreg[DATA_W-1] at all times, registered.
- Load and dump strobes in the same cycle: both ignored; state and counters unchanged.
- Bit counter is $clog2(DATA_W)+1 bits wide; no wrap-around.

Decomposition:
- Package spell_dbg_pkg:
  - state enum;
  - REG_PC=2'd0, REG_SP=2'd1, REG_EXEC=2'd2, REG_STACK=2'd3.
- Sub-module spell_sync_edge: SYNC_STAGES synchroniser with optional rising-edge output.
  - Instantiated for i_load and i_dump with edge output.
  - Instantiated in plain form for i_shift_in and i_reg_sel.

Test Plan:
- Write: reg_sel=1, 8 load edges with bits 1,0,1,0,0,1,1,0, i_wr_ready=1 -> exactly one cycle with o_wr_valid=1, o_wr_sel=1, o_wr_data=8'hA6.
- Backpressure: same write with i_wr_ready=0 for 5 cycles, plus 2 extra load edges meanwhile -> o_wr_valid held 5+ cycles with data 8'hA6; the extra edges have no effect; cleared the cycle after ready=1.
- Dump: reg_sel=0, core returns 8'h3C -> o_rd_req single pulse, o_rd_sel=0; o_shift_out reads 0,0,1,1,1,1,0,0 across dump edges 1..8; o_busy low after edge 8.
- Abort: 3 load edges, then a dump edge -> no o_wr_valid; read starts. A load edge mid-dump -> dump aborted, cnt=1, state LOAD.
- Reset mid-WR_PEND with o_wr_valid=1 -> next cycle all outputs 0, o_busy=0.
- Glitch: load pulse shorter than one clk but sampled once -> counted as one bit. Load and dump rising on the same clk -> both ignored.

Source files
------------

// File: rtl/spell_dbg_pkg.sv
// Shared state encoding and register-select constants for the SPELL debug port.
package spell_dbg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WR_PEND,
        RD_REQ,
        RD_CAP,
        DUMP
    } dbgState_e;

    localparam logic [1:0] REG_PC    = 2'd0;
    localparam logic [1:0] REG_SP    = 2'd1;
    localparam logic [1:0] REG_EXEC  = 2'd2;
    localparam logic [1:0] REG_STACK = 2'd3;

    // One spare bit so a full count of DATA_W never wraps to zero.
    function automatic int cntWidth(input int dataW);
        return $clog2(dataW) + 1;
    endfunction

endpackage

// File: rtl/spell_sync_edge.sv
// Multi-flop synchroniser for asynchronous pins, with an optional rising-edge
// strobe built from the last synchroniser stage and one extra history flop.
module spell_sync_edge #(
    parameter int WIDTH   = 1,
    parameter int STAGES  = 2,
    parameter bit EDGE_EN = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] async_i,
    output logic [WIDTH-1:0] sync_o,
    output logic [WIDTH-1:0] rise_o
);

    // Fewer than two stages would not settle metastability.
    localparam int NSTAGES = (STAGES < 2) ? 2 : STAGES;

    logic [WIDTH-1:0] stage_q [NSTAGES];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NSTAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= async_i;
            for (int i = 1; i < NSTAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign sync_o = stage_q[NSTAGES-1];

    generate
        if (EDGE_EN) begin : g_edge
            logic [WIDTH-1:0] prev_q;

            always_ff @(posedge clk) begin
                if (reset) begin
                    prev_q <= '0;
                end else begin
                    prev_q <= stage_q[NSTAGES-1];
                end
            end

            assign rise_o = stage_q[NSTAGES-1] & ~prev_q;
        end else begin : g_level
            assign rise_o = '0;
        end
    endgenerate

endmodule

// File: rtl/spell_dbg_port.sv
// Serial debug front-end for the SPELL core: turns pin-level load/dump strobes
// into parallel register writes and reads, and shifts read data back out.
module spell_dbg_port
    import spell_dbg_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_load,
    input  logic              i_dump,
    input  logic              i_shift_in,
    input  logic [1:0]        i_reg_sel,
    output logic              o_shift_out,
    output logic              o_wr_valid,
    input  logic              i_wr_ready,
    output logic [1:0]        o_wr_sel,
    output logic [DATA_W-1:0] o_wr_data,
    output logic              o_rd_req,
    output logic [1:0]        o_rd_sel,
    input  logic [DATA_W-1:0] i_rd_data,
    output logic              o_busy
);

    localparam int               CNT_W    = cntWidth(DATA_W);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);

    logic       loadRise;
    logic       dumpRise;
    logic       shiftInSync;
    logic [1:0] regSelSync;
    logic       unusedLoadLevel;
    logic       unusedDumpLevel;
    logic       unusedShiftInRise;
    logic [1:0] unusedRegSelRise;

    spell_sync_edge #(
        .WIDTH   (1),
        .STAGES  (SYNC_STAGES),
        .EDGE_EN (1'b1)
    ) u_load_sync (
        .clk     (clk),
        .reset   (reset),
        .async_i (i_load),
        .sync_o  (unusedLoadLevel),
        .rise_o  (loadRise)
    );

    spell_sync_edge #(
        .WIDTH   (1),
        .STAGES  (SYNC_STAGES),
        .EDGE_EN (1'b1)
    ) u_dump_sync (
        .clk     (clk),
        .reset   (reset),
        .async_i (i_dump),
        .sync_o  (unusedDumpLevel),
        .rise_o  (dumpRise)
    );

    // Data and select use the same depth as the strobes so they stay aligned.
    spell_sync_edge #(
        .WIDTH   (1),
        .STAGES  (SYNC_STAGES),
        .EDGE_EN (1'b0)
    ) u_shift_in_sync (
        .clk     (clk),
        .reset   (reset),
        .async_i (i_shift_in),
        .sync_o  (shiftInSync),
        .rise_o  (unusedShiftInRise)
    );

    spell_sync_edge #(
        .WIDTH   (2),
        .STAGES  (SYNC_STAGES),
        .EDGE_EN (1'b0)
    ) u_reg_sel_sync (
        .clk     (clk),
        .reset   (reset),
        .async_i (i_reg_sel),
        .sync_o  (regSelSync),
        .rise_o  (unusedRegSelRise)
    );

    dbgState_e         state_q;
    logic [DATA_W-1:0] shiftReg_q;
    logic [DATA_W-1:0] wrData_q;
    logic [CNT_W-1:0]  bitCnt_q;
    logic              wrValid_q;
    logic              rdReq_q;
    logic [1:0]        wrSel_q;
    logic [1:0]        rdSel_q;

    logic              loadOnly;
    logic              dumpOnly;
    logic [CNT_W-1:0]  cntInc_d;
    logic [DATA_W-1:0] loadShift_d;
    logic [DATA_W-1:0] dumpShift_d;

    // Coincident load and dump strobes cancel each other out.
    assign loadOnly    = loadRise & ~dumpRise;
    assign dumpOnly    = dumpRise & ~loadRise;
    assign cntInc_d    = bitCnt_q + CNT_ONE;
    assign loadShift_d = {shiftReg_q[DATA_W-2:0], shiftInSync};
    assign dumpShift_d = {shiftReg_q[DATA_W-2:0], 1'b0};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            shiftReg_q <= '0;
            wrData_q   <= '0;
            bitCnt_q   <= '0;
            wrValid_q  <= 1'b0;
            rdReq_q    <= 1'b0;
            wrSel_q    <= REG_PC;
            rdSel_q    <= REG_PC;
        end else begin
            case (state_q)
                IDLE, LOAD: begin
                    if (loadOnly) begin
                        shiftReg_q <= loadShift_d;
                        bitCnt_q   <= cntInc_d;
                        if (cntInc_d == CNT_FULL) begin
                            wrSel_q   <= regSelSync;
                            wrData_q  <= loadShift_d;
                            wrValid_q <= 1'b1;
                            state_q   <= WR_PEND;
                        end else begin
                            state_q <= LOAD;
                        end
                    end else if (dumpOnly) begin
                        // Any partially shifted write is simply dropped here.
                        bitCnt_q <= CNT_ONE;
                        rdSel_q  <= regSelSync;
                        rdReq_q  <= 1'b1;
                        state_q  <= RD_REQ;
                    end
                end
                WR_PEND: begin
                    if (i_wr_ready) begin
                        wrValid_q <= 1'b0;
                        bitCnt_q  <= '0;
                        state_q   <= IDLE;
                    end
                end
                RD_REQ: begin
                    rdReq_q <= 1'b0;
                    state_q <= RD_CAP;
                end
                RD_CAP: begin
                    shiftReg_q <= i_rd_data;
                    state_q    <= DUMP;
                end
                DUMP: begin
                    if (loadOnly) begin
                        shiftReg_q <= loadShift_d;
                        bitCnt_q   <= CNT_ONE;
                        state_q    <= LOAD;
                    end else if (dumpOnly) begin
                        shiftReg_q <= dumpShift_d;
                        if (cntInc_d == CNT_FULL) begin
                            bitCnt_q <= '0;
                            state_q  <= IDLE;
                        end else begin
                            bitCnt_q <= cntInc_d;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign o_shift_out = shiftReg_q[DATA_W-1];
    assign o_wr_valid  = wrValid_q;
    assign o_wr_sel    = wrSel_q;
    assign o_wr_data   = wrData_q;
    assign o_rd_req    = rdReq_q;
    assign o_rd_sel    = rdSel_q;
    assign o_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_spell_dbg_port.sv
// Scoreboard bench for spell_dbg_port: expected writes and dump bits are queued
// as stimulus is driven and compared when the port produces them.
module tb_spell_dbg_port;

    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              i_load;
    logic              i_dump;
    logic              i_shift_in;
    logic [1:0]        i_reg_sel;
    logic              o_shift_out;
    logic              o_wr_valid;
    logic              i_wr_ready;
    logic [1:0]        o_wr_sel;
    logic [DATA_W-1:0] o_wr_data;
    logic              o_rd_req;
    logic [1:0]        o_rd_sel;
    logic [DATA_W-1:0] i_rd_data = 8'h5A;
    logic              o_busy;

    int checks = 0;
    int errors = 0;

    int                wrValidCycles = 0;
    int                rdReqCycles   = 0;
    int                hsCount       = 0;
    int                wrRead        = 0;
    logic [1:0]        lastRdSel     = 2'd0;
    logic              rdReqSeen     = 1'b0;
    logic [1:0]        rdSelSeen     = 2'd0;
    logic [DATA_W+1:0] obsWr [64];
    logic [DATA_W-1:0] regFile [4];

    logic [DATA_W+1:0] expWrQ [$];
    logic              expBitQ [$];

    spell_dbg_port #(
        .DATA_W      (DATA_W),
        .SYNC_STAGES (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .i_load      (i_load),
        .i_dump      (i_dump),
        .i_shift_in  (i_shift_in),
        .i_reg_sel   (i_reg_sel),
        .o_shift_out (o_shift_out),
        .o_wr_valid  (o_wr_valid),
        .i_wr_ready  (i_wr_ready),
        .o_wr_sel    (o_wr_sel),
        .o_wr_data   (o_wr_data),
        .o_rd_req    (o_rd_req),
        .o_rd_sel    (o_rd_sel),
        .i_rd_data   (i_rd_data),
        .o_busy      (o_busy)
    );

    always #5 clk = ~clk;

    // Monitor on the falling edge: log accepted writes and read requests.
    always @(negedge clk) begin
        if (!reset) begin
            if (o_wr_valid) wrValidCycles++;
            if (o_wr_valid && i_wr_ready && hsCount < 64) begin
                obsWr[hsCount] = {o_wr_sel, o_wr_data};
                hsCount++;
            end
            if (o_rd_req) begin
                rdReqCycles++;
                lastRdSel = o_rd_sel;
            end
        end
        rdReqSeen = o_rd_req;
        rdSelSeen = o_rd_sel;
    end

    // Core model: read data is valid only in the cycle after the request.
    always begin
        @(posedge clk);
        #2;
        i_rd_data = rdReqSeen ? regFile[rdSelSeen] : 8'h5A;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic applyLoadEdge(input logic b);
        i_shift_in = b;
        waitCycles(1);
        i_load = 1'b1;
        waitCycles(4);
        i_load = 1'b0;
        waitCycles(4);
    endtask

    task automatic applyDumpEdge();
        i_dump = 1'b1;
        waitCycles(4);
        i_dump = 1'b0;
        waitCycles(4);
    endtask

    task automatic waitForWrite(input int maxCycles, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < maxCycles && !seen; i++) begin
            if (hsCount > wrRead) seen = 1'b1;
            else waitCycles(1);
        end
    endtask

    task automatic waitForValid(input int maxCycles, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < maxCycles && !seen; i++) begin
            @(negedge clk);
            if (o_wr_valid === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        waitCycles(3);
        @(negedge clk);
        checks++;
        if ({o_wr_valid, o_rd_req, o_busy, o_shift_out} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: got %b expected 0000",
                     {o_wr_valid, o_rd_req, o_busy, o_shift_out});
        end
        checks++;
        if ({o_wr_sel, o_rd_sel, o_wr_data} !== 12'h000) begin
            errors++;
            $display("[TB] FAIL reset_data: got %h expected 000",
                     {o_wr_sel, o_rd_sel, o_wr_data});
        end
        waitCycles(1);
        reset = 1'b0;
        waitCycles(4);
        @(negedge clk);
        checks++;
        if (o_busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL idle_after_reset: busy %b expected 0", o_busy);
        end
    endtask

    task automatic test_write();
        logic [7:0]        bits    = 8'b1010_0110;
        logic [DATA_W-1:0] expData = '0;
        logic [DATA_W+1:0] expW;
        logic [DATA_W+1:0] obsW;
        int                vBase   = wrValidCycles;
        bit                seen;
        $display("[TB] test_write");
        i_wr_ready = 1'b1;
        i_reg_sel  = 2'd1;
        for (int i = 7; i >= 0; i--) expData = {expData[DATA_W-2:0], bits[i]};
        expWrQ.push_back({2'd1, expData});
        for (int i = 7; i >= 0; i--) applyLoadEdge(bits[i]);
        waitForWrite(40, seen);
        expW = expWrQ.pop_front();
        checks++;
        if (!seen) begin
            errors++;
            $display("[TB] FAIL write_timeout: no write, expected %h", expW);
        end else begin
            obsW = obsWr[wrRead];
            wrRead++;
            if (obsW !== expW) begin
                errors++;
                $display("[TB] FAIL write_data: got sel/data %h expected %h", obsW, expW);
            end
        end
        waitCycles(3);
        @(negedge clk);
        checks++;
        if (wrValidCycles - vBase !== 1) begin
            errors++;
            $display("[TB] FAIL write_valid_len: got %0d cycles expected 1", wrValidCycles - vBase);
        end
        checks++;
        if (o_busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL write_busy_end: got %b expected 0", o_busy);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0]        bits    = 8'b1010_0110;
        logic [DATA_W-1:0] expData = '0;
        logic [DATA_W+1:0] expW;
        logic [DATA_W+1:0] obsW;
        int                vBase   = wrValidCycles;
        bit                seen;
        $display("[TB] test_backpressure");
        i_wr_ready = 1'b0;
        i_reg_sel  = 2'd1;
        for (int i = 7; i >= 0; i--) expData = {expData[DATA_W-2:0], bits[i]};
        expWrQ.push_back({2'd1, expData});
        for (int i = 7; i >= 0; i--) applyLoadEdge(bits[i]);
        waitForValid(20, seen);
        checks++;
        if (!seen) begin
            errors++;
            $display("[TB] FAIL bp_valid_timeout: valid %b expected 1", o_wr_valid);
        end
        i_reg_sel = 2'd3;
        applyLoadEdge(1'b1);
        applyLoadEdge(1'b0);
        @(negedge clk);
        checks++;
        if ({o_wr_valid, o_wr_sel, o_wr_data} !== {1'b1, 2'd1, expData}) begin
            errors++;
            $display("[TB] FAIL bp_held: got %h expected %h",
                     {o_wr_valid, o_wr_sel, o_wr_data}, {1'b1, 2'd1, expData});
        end
        checks++;
        if (wrValidCycles - vBase < 5) begin
            errors++;
            $display("[TB] FAIL bp_hold_len: got %0d cycles expected at least 5", wrValidCycles - vBase);
        end
        waitCycles(1);
        i_wr_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (o_wr_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bp_clear: valid %b expected 0", o_wr_valid);
        end
        expW = expWrQ.pop_front();
        checks++;
        if (hsCount <= wrRead) begin
            errors++;
            $display("[TB] FAIL bp_write_missing: no write, expected %h", expW);
        end else begin
            obsW = obsWr[wrRead];
            wrRead++;
            if (obsW !== expW) begin
                errors++;
                $display("[TB] FAIL bp_write_data: got %h expected %h", obsW, expW);
            end
        end
        waitCycles(30);
        @(negedge clk);
        checks++;
        if ({o_busy, 1'b0} !== 2'b00 || hsCount != wrRead) begin
            errors++;
            $display("[TB] FAIL bp_extra_edges: busy %b extra writes %0d expected 0 0",
                     o_busy, hsCount - wrRead);
        end
    endtask

    task automatic test_dump();
        logic [DATA_W-1:0] regVal = regFile[0];
        int                rBase  = rdReqCycles;
        logic              expBit;
        $display("[TB] test_dump");
        i_reg_sel = 2'd0;
        for (int i = DATA_W - 1; i >= 0; i--) expBitQ.push_back(regVal[i]);
        for (int k = 1; k <= DATA_W; k++) begin
            applyDumpEdge();
            @(negedge clk);
            expBit = expBitQ.pop_front();
            checks++;
            if (o_shift_out !== expBit) begin
                errors++;
                $display("[TB] FAIL dump_bit%0d: got %b expected %b", k, o_shift_out, expBit);
            end
            if (k == 1) begin
                checks++;
                if (rdReqCycles - rBase !== 1 || lastRdSel !== 2'd0) begin
                    errors++;
                    $display("[TB] FAIL dump_rd_req: got %0d pulses sel %0d expected 1 pulse sel 0",
                             rdReqCycles - rBase, lastRdSel);
                end
                checks++;
                if (o_busy !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL dump_busy_mid: got %b expected 1", o_busy);
                end
            end
        end
        checks++;
        if (o_busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL dump_busy_end: got %b expected 0", o_busy);
        end
        checks++;
        if (rdReqCycles - rBase !== 1) begin
            errors++;
            $display("[TB] FAIL dump_single_req: got %0d pulses expected 1", rdReqCycles - rBase);
        end
    endtask

    task automatic test_abort();
        logic [DATA_W-1:0] regVal  = regFile[3];
        logic [7:0]        bits    = 8'b1100_1011;
        logic [DATA_W-1:0] expData = '0;
        logic [DATA_W+1:0] expW;
        logic [DATA_W+1:0] obsW;
        int                vBase   = wrValidCycles;
        int                rBase   = rdReqCycles;
        logic              expBit;
        bit                seen;
        $display("[TB] test_abort");
        i_wr_ready = 1'b1;
        i_reg_sel  = 2'd2;
        for (int i = 0; i < 3; i++) applyLoadEdge(1'b1);
        i_reg_sel = 2'd3;
        expBitQ.push_back(regVal[DATA_W-1]);
        expBitQ.push_back(regVal[DATA_W-2]);
        applyDumpEdge();
        @(negedge clk);
        checks++;
        if (wrValidCycles != vBase || hsCount != wrRead) begin
            errors++;
            $display("[TB] FAIL abort_no_write: got %0d valid cycles expected 0", wrValidCycles - vBase);
        end
        checks++;
        if (rdReqCycles - rBase !== 1 || lastRdSel !== 2'd3) begin
            errors++;
            $display("[TB] FAIL abort_rd_req: got %0d pulses sel %0d expected 1 pulse sel 3",
                     rdReqCycles - rBase, lastRdSel);
        end
        for (int k = 1; k <= 2; k++) begin
            if (k == 2) applyDumpEdge();
            @(negedge clk);
            expBit = expBitQ.pop_front();
            checks++;
            if (o_shift_out !== expBit) begin
                errors++;
                $display("[TB] FAIL abort_dump_bit%0d: got %b expected %b", k, o_shift_out, expBit);
            end
        end
        i_reg_sel = 2'd2;
        for (int i = 7; i >= 0; i--) expData = {expData[DATA_W-2:0], bits[i]};
        expWrQ.push_back({2'd2, expData});
        applyLoadEdge(bits[7]);
        @(negedge clk);
        checks++;
        if ({o_busy, o_wr_valid} !== 2'b10 || rdReqCycles - rBase !== 1) begin
            errors++;
            $display("[TB] FAIL abort_to_load: busy/valid %b reads %0d expected 10 and 1",
                     {o_busy, o_wr_valid}, rdReqCycles - rBase);
        end
        for (int i = 6; i >= 1; i--) applyLoadEdge(bits[i]);
        checks++;
        if (hsCount != wrRead) begin
            errors++;
            $display("[TB] FAIL abort_early_write: got %0d writes after 7 bits expected 0", hsCount - wrRead);
        end
        applyLoadEdge(bits[0]);
        waitForWrite(40, seen);
        expW = expWrQ.pop_front();
        checks++;
        if (!seen) begin
            errors++;
            $display("[TB] FAIL abort_write_timeout: no write, expected %h", expW);
        end else begin
            obsW = obsWr[wrRead];
            wrRead++;
            if (obsW !== expW) begin
                errors++;
                $display("[TB] FAIL abort_write_data: got %h expected %h", obsW, expW);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] bits = 8'b1101_0011;
        bit         seen;
        $display("[TB] test_reset_mid");
        i_wr_ready = 1'b0;
        i_reg_sel  = 2'd2;
        for (int i = 7; i >= 0; i--) applyLoadEdge(bits[i]);
        waitForValid(20, seen);
        checks++;
        if (!seen || o_shift_out !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rst_mid_setup: valid %b shift_out %b expected 1 1", o_wr_valid, o_shift_out);
        end
        waitCycles(1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({o_wr_valid, o_busy, o_rd_req, o_shift_out, o_wr_sel, o_rd_sel, o_wr_data} !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL rst_mid_outputs: got %h expected 0000",
                     {o_wr_valid, o_busy, o_rd_req, o_shift_out, o_wr_sel, o_rd_sel, o_wr_data});
        end
        waitCycles(1);
        reset      = 1'b0;
        i_wr_ready = 1'b1;
        waitCycles(10);
        @(negedge clk);
        checks++;
        if (o_wr_valid !== 1'b0 || hsCount != wrRead) begin
            errors++;
            $display("[TB] FAIL rst_mid_no_write: valid %b writes %0d expected 0 0", o_wr_valid, hsCount - wrRead);
        end
    endtask

    task automatic test_glitch();
        logic [7:0]        bits    = 8'b0110_1101;
        logic [DATA_W-1:0] expData = '0;
        logic [DATA_W+1:0] expW;
        logic [DATA_W+1:0] obsW;
        int                vBase   = wrValidCycles;
        int                rBase   = rdReqCycles;
        bit                seen;
        $display("[TB] test_glitch");
        i_wr_ready = 1'b1;
        i_reg_sel  = 2'd1;
        for (int i = 7; i >= 0; i--) expData = {expData[DATA_W-2:0], bits[i]};
        expWrQ.push_back({2'd1, expData});
        i_shift_in = bits[7];
        waitCycles(1);
        #6;
        i_load = 1'b1;
        #4;
        i_load = 1'b0;
        waitCycles(5);
        @(negedge clk);
        checks++;
        if (o_busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL glitch_counted: busy %b expected 1", o_busy);
        end
        for (int i = 6; i >= 4; i--) applyLoadEdge(bits[i]);
        i_shift_in = ~bits[3];
        waitCycles(1);
        i_load = 1'b1;
        i_dump = 1'b1;
        waitCycles(4);
        i_load = 1'b0;
        i_dump = 1'b0;
        waitCycles(4);
        @(negedge clk);
        checks++;
        if (o_busy !== 1'b1 || rdReqCycles != rBase) begin
            errors++;
            $display("[TB] FAIL both_strobes: busy %b reads %0d expected 1 0", o_busy, rdReqCycles - rBase);
        end
        for (int i = 3; i >= 0; i--) applyLoadEdge(bits[i]);
        waitForWrite(40, seen);
        expW = expWrQ.pop_front();
        checks++;
        if (!seen) begin
            errors++;
            $display("[TB] FAIL glitch_write_timeout: no write, expected %h", expW);
        end else begin
            obsW = obsWr[wrRead];
            wrRead++;
            if (obsW !== expW) begin
                errors++;
                $display("[TB] FAIL glitch_write_data: got %h expected %h", obsW, expW);
            end
        end
        waitCycles(2);
        checks++;
        if (wrValidCycles - vBase !== 1) begin
            errors++;
            $display("[TB] FAIL glitch_valid_len: got %0d cycles expected 1", wrValidCycles - vBase);
        end
    endtask

    initial begin
        reset      = 1'b1;
        i_load     = 1'b0;
        i_dump     = 1'b0;
        i_shift_in = 1'b0;
        i_reg_sel  = 2'd0;
        i_wr_ready = 1'b0;
        regFile[0] = 8'h3C;
        regFile[1] = 8'h00;
        regFile[2] = 8'h00;
        regFile[3] = 8'h81;

        test_reset();
        test_write();
        test_backpressure();
        test_dump();
        test_abort();
        test_reset_mid();
        test_glitch();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
